ps2_note_scheduler: RTL and testbench
=====================================

// Module: ps2_note_scheduler
// PURPOSE
//  Sits between the PS/2 byte receiver and the note half-period lookup/tone generator.
//  Parses make/break scan-code sequences (F0 break prefix, E0 extended prefix) and
//  tracks currently held keys in a last-pressed-priority stack.
//  Grants the single tone generator to the most recently pressed key still held.
//  Outputs that key's scan code plus note-on and note-change status.
// PARAMETERS
//  DEPTH    4        held-key stack entries (2..8)
//  TIMEOUT  56_000   CLK cycles a prefix state may wait for its next byte before abort
// PORTS
//  CLK          in   1    system clock, all logic on posedge
//  RST_N        in   1    asynchronous active-low reset
//  byte_data    in   8    received scan-code byte, valid only with byte_valid
//  byte_valid   in   1    one-cycle strobe, one per received byte
//  byte_err     in   1    one-cycle strobe, parity/framing error on current byte
//  note_code    out  8    scan code of active note (stack top), 8'h00 when none
//  note_on      out  1    1 while at least one key is held
//  note_change  out  1    one-cycle pulse when note_code or note_on changes
//  held_count   out  4    number of valid stack entries, 0..DEPTH
// BEHAVIOUR
//  Reset (async, RST_N=0):
//  - all outputs 0; stack empty; parser FSM in IDLE; timeout counter 0.
//  Parser FSM, advances only on byte_valid:
//  - IDLE: F0 -> BRK; E0 -> EXT; 00 or FF -> clear stack, stay IDLE;
//    any other code -> MAKE(code).
//  - BRK: any code -> BREAK(code), then IDLE.
//  - EXT: F0 -> EXT_BRK; any other byte -> discard, then IDLE.
//  - EXT_BRK: any byte -> discard, then IDLE. Extended keys never reach the stack.
//  Timeout:
//  - In BRK/EXT/EXT_BRK, count CLK cycles without byte_valid.
//  - Reaching TIMEOUT returns the FSM to IDLE with no stack change.
//  - Counter clears on every byte_valid and on every entry to IDLE.
//  byte_err:
//  - Byte is discarded; FSM -> IDLE; stack unchanged.
//  - byte_err with byte_valid in the same cycle: byte_err wins.
//  MAKE(code):
//  - code already in stack (typematic repeat): no change; it does not move to top.
//  - not present, stack not full: push on top, held_count+1.
//  - not present, stack full: drop bottom (oldest) entry, shift down, push on top;
//    held_count stays DEPTH.
//  BREAK(code):
//  - code in stack: remove it, compact entries above it down by one, held_count-1.
//    Order of the remaining entries is preserved.
//  - code not in stack: ignored.
//  Outputs:
//  - Registered, valid on the CLK edge after the byte_valid cycle (1-cycle latency).
//  - note_code = top entry, or 8'h00 when the stack is empty.
//  - note_on = (held_count != 0).
//  - note_change is high for exactly the one cycle in which new note_code/note_on
//    values first appear. It stays 0 when an event leaves both unchanged
//    (repeat, or break of a non-top key).
//  Reset mid-sequence: RST_N low at any time clears stack and FSM immediately.
// TESTING
//  - Reset, then MAKE 1C -> next cycle note_code=1C, note_on=1, held_count=1,
//    note_change pulse 1 cycle.
//  - 1C, 1B, F0 1B -> note_code 1C->1B->1C, held_count 1,2,1; 3 change pulses total.
//  - 1C,1B,23,2B held; break 1B -> top stays 2B, order 1C,23,2B, no note_change;
//    F0 2B -> note_code=23.
//  - DEPTH=4 full (1C,1B,23,2B); make 34 -> 1C dropped, note_code=34, held_count=4;
//    F0 1C -> ignored.
//  - Repeat make 1C x5 while held -> no change, no pulse; E0 75 and E0 F0 75 ->
//    stack untouched.
//  - F0 then silence TIMEOUT cycles -> FSM IDLE; next 1C treated as MAKE (note_on=1).
//  - F0 with byte_err on the next byte -> no break applied.
//  - RST_N low mid F0 -> immediate reset values.

Source files
------------

// File: rtl/ps2_note_scheduler.sv
// ps2_note_scheduler: parses PS/2 make/break codes into a last-pressed-priority held-key stack
module ps2_note_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 56_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_err,
    output logic [7:0] note_code,
    output logic       note_on,
    output logic       note_change,
    output logic [3:0] held_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BRK     = 2'd1;
    localparam logic [1:0] EXT     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    logic [1:0]    st, st_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [7:0]    stk [DEPTH];
    logic [7:0]    stk_n [DEPTH];
    logic [3:0]    cnt_n, pos;
    logic [7:0]    top_n;
    logic          ev, hit, mk, brk, clr, expire;

    // Parser: an erroneous byte aborts any prefix, a silent prefix times out back to IDLE
    always_comb begin
        ev     = byte_valid && !byte_err;
        expire = st != IDLE && tcnt == TW'(TIMEOUT - 1);
        clr    = ev && st == IDLE && (byte_data == 8'h00 || byte_data == 8'hFF);
        mk     = ev && st == IDLE && !clr && byte_data != 8'hF0 && byte_data != 8'hE0;
        brk    = ev && st == BRK;
        st_n   = byte_err ? IDLE :
                 byte_valid ? (st == IDLE ? (byte_data == 8'hF0 ? BRK : byte_data == 8'hE0 ? EXT : IDLE) :
                               (st == EXT && byte_data == 8'hF0) ? EXT_BRK : IDLE) :
                 expire ? IDLE : st;
        tcnt_n = (byte_valid || byte_err || st_n == IDLE) ? '0 : tcnt + 1'b1;
    end

    // Stack update: stk[0] is the oldest entry, stk[held_count-1] is the active note
    always_comb begin
        hit = 1'b0;
        pos = '0;
        for (int i = 0; i < DEPTH; i++)
            if (!hit && 4'(i) < held_count && stk[i] == byte_data) begin
                hit = 1'b1;
                pos = 4'(i);
            end
        stk_n = stk;
        cnt_n = held_count;
        if (clr)
            cnt_n = '0;
        else if (mk && !hit) begin
            if (held_count == 4'(DEPTH)) begin
                for (int i = 0; i < DEPTH - 1; i++) stk_n[i] = stk[i+1];
                stk_n[DEPTH-1] = byte_data;
            end else begin
                for (int i = 0; i < DEPTH; i++) if (4'(i) == held_count) stk_n[i] = byte_data;
                cnt_n = held_count + 4'd1;
            end
        end else if (brk && hit) begin
            for (int i = 0; i < DEPTH - 1; i++) if (4'(i) >= pos) stk_n[i] = stk[i+1];
            cnt_n = held_count - 4'd1;
        end
        top_n = '0;
        for (int i = 0; i < DEPTH; i++) if (4'(i) + 4'd1 == cnt_n) top_n = stk_n[i];
    end

    // Parser state and prefix timeout counter
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            st   <= IDLE;
            tcnt <= '0;
        end else begin
            st   <= st_n;
            tcnt <= tcnt_n;
        end

    // Stack storage and registered note outputs; note_change flags a new code/on value
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            held_count  <= '0;
            note_code   <= '0;
            note_on     <= 1'b0;
            note_change <= 1'b0;
        end else begin
            stk         <= stk_n;
            held_count  <= cnt_n;
            note_code   <= top_n;
            note_on     <= cnt_n != 4'd0;
            note_change <= top_n != note_code || (cnt_n != 4'd0) != note_on;
        end
endmodule

// File: tb/tb_ps2_note_scheduler.sv
// tb_ps2_note_scheduler: directed stimulus checked every cycle against a queue-based key model
module tb_ps2_note_scheduler;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] byte_data = '0;
    logic       byte_valid = 1'b0;
    logic       byte_err = 1'b0;
    logic [7:0] note_code;
    logic       note_on, note_change;
    logic [3:0] held_count;

    ps2_note_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_N(RST_N), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_err(byte_err), .note_code(note_code), .note_on(note_on),
        .note_change(note_change), .held_count(held_count)
    );

    always #5 CLK = ~CLK;

    int vecs = 0;
    int errs = 0;
    int pulses = 0;
    bit count_pulses = 1'b0;

    // Model: held keys oldest-first, prefix mode (0 none, 1 break, 2 ext, 3 ext-break)
    logic [7:0] mq[$];
    int         mode = 0;
    int         silent = 0;
    logic [7:0] exp_code = '0;
    logic       exp_on = 1'b0;
    logic       exp_change = 1'b0;

    task automatic model_reset();
        mq.delete();
        mode = 0;
        silent = 0;
        exp_code = '0;
        exp_on = 1'b0;
        exp_change = 1'b0;
    endtask

    function automatic int find(logic [7:0] c);
        for (int i = 0; i < mq.size(); i++) if (mq[i] == c) return i;
        return -1;
    endfunction

    task automatic model_step(bit v, bit e, logic [7:0] d);
        logic [7:0] nc;
        logic       no;
        int         k;
        if (e) begin
            mode = 0;
            silent = 0;
        end else if (v) begin
            silent = 0;
            case (mode)
                0: begin
                    if (d == 8'hF0) mode = 1;
                    else if (d == 8'hE0) mode = 2;
                    else if (d == 8'h00 || d == 8'hFF) mq.delete();
                    else if (find(d) < 0) begin
                        if (mq.size() == DEPTH) void'(mq.pop_front());
                        mq.push_back(d);
                    end
                end
                1: begin
                    k = find(d);
                    if (k >= 0) mq.delete(k);
                    mode = 0;
                end
                2: mode = (d == 8'hF0) ? 3 : 0;
                default: mode = 0;
            endcase
        end else if (mode != 0) begin
            silent++;
            if (silent >= TIMEOUT) begin
                mode = 0;
                silent = 0;
            end
        end
        nc = mq.size() == 0 ? 8'h00 : mq[mq.size()-1];
        no = mq.size() != 0;
        exp_change = (nc != exp_code) || (no != exp_on);
        exp_code = nc;
        exp_on = no;
    endtask

    task automatic cmp(string nm, logic [15:0] act, logic [15:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic compare_all();
        cmp("note_code", 16'(note_code), 16'(exp_code));
        cmp("note_on", 16'(note_on), 16'(exp_on));
        cmp("held_count", 16'(held_count), 16'(mq.size()));
        cmp("note_change", 16'(note_change), 16'(exp_change));
        if (count_pulses && note_change) pulses++;
    endtask

    // One clock of stimulus: drive at negedge, model at posedge, compare at next negedge
    task automatic cyc(bit v, bit e, logic [7:0] d);
        byte_valid = v;
        byte_err = e;
        byte_data = d;
        @(posedge CLK);
        model_step(v, e, d);
        @(negedge CLK);
        byte_valid = 1'b0;
        byte_err = 1'b0;
        compare_all();
    endtask

    task automatic send(logic [7:0] d);
        cyc(1'b1, 1'b0, d);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic pin(string nm, logic [7:0] c, logic [3:0] n);
        cmp({nm, ".code"}, 16'(note_code), 16'(c));
        cmp({nm, ".count"}, 16'(held_count), 16'(n));
        cmp({nm, ".on"}, 16'(note_on), 16'(n != 0));
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        pin("reset", 8'h00, 4'd0);
        cmp("reset.change", 16'(note_change), 16'd0);
        RST_N = 1'b1;
        idle(2);

        send(8'h1C);
        pin("make1C", 8'h1C, 4'd1);
        cmp("make1C.change", 16'(note_change), 16'd1);
        idle(1);
        cmp("make1C.pulse_end", 16'(note_change), 16'd0);

        send(8'h00);
        idle(1);
        count_pulses = 1'b1;
        send(8'h1C); send(8'h1B); send(8'hF0); send(8'h1B);
        idle(2);
        count_pulses = 1'b0;
        cmp("three_pulses", 16'(pulses), 16'd3);
        pin("after_break1B", 8'h1C, 4'd1);

        send(8'h00);
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        send(8'hF0); send(8'h1B);
        pin("break_non_top", 8'h2B, 4'd3);
        cmp("break_non_top.change", 16'(note_change), 16'd0);
        send(8'hF0); send(8'h2B);
        pin("break_top", 8'h23, 4'd2);

        send(8'h00);
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        send(8'h34);
        pin("overflow", 8'h34, 4'd4);
        send(8'hF0); send(8'h1C);
        pin("break_dropped", 8'h34, 4'd4);
        send(8'hF0); send(8'h34);
        send(8'hF0); send(8'h2B);
        pin("order_kept", 8'h23, 4'd2);

        send(8'h00);
        send(8'h1C);
        for (int i = 0; i < 5; i++) send(8'h1C);
        pin("typematic", 8'h1C, 4'd1);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        pin("extended", 8'h1C, 4'd1);
        send(8'hE0); send(8'hF0); send(8'h1C);
        pin("ext_break_ignored", 8'h1C, 4'd1);

        send(8'hF0);
        idle(TIMEOUT - 4);
        send(8'h1C);
        pin("break_before_timeout", 8'h00, 4'd0);

        send(8'hF0);
        idle(TIMEOUT + 2);
        send(8'h1C);
        pin("timeout_then_make", 8'h1C, 4'd1);

        send(8'hF0);
        cyc(1'b1, 1'b1, 8'h1C);
        idle(1);
        send(8'h1C);
        pin("err_aborts_break", 8'h1C, 4'd1);
        send(8'hE0);
        cyc(1'b0, 1'b1, 8'h00);
        send(8'h1B);
        pin("err_aborts_ext", 8'h1B, 4'd2);

        send(8'hF0);
        #2 RST_N = 1'b0;
        #1;
        pin("async_reset", 8'h00, 4'd0);
        cmp("async_reset.change", 16'(note_change), 16'd0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        send(8'h1C);
        pin("after_reset_make", 8'h1C, 4'd1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
